// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 instruction fetch front end.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic {
        RUN,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two instruction queue of {instr, pc} entries with push, pop and flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;

    // NOTE: the storage array has no reset; count gates every read, so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32 fetch front end: credit-limited imem requests, in-order responses, redirect flush.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_pc_plus4,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int          CW        = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, resp_pc_q, redirect_target;
    logic [CW-1:0]   outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d, count;
    logic [CW:0]     drop_sum;
    fetch_state_t    state_q, state_d;
    fetch_entry_t    head, push_entry;
    logic            req_fire, resp_live, bypass, push, pop, queued;

    assign redirect_target = redirect_pc & ~XLEN'(3);
    assign queued          = (count != '0);

    // Gating with rst_n keeps the request line low while reset is held.
    assign imem_req_valid = rst_n && !redirect
                          && (({1'b0, count} + {1'b0, outstanding_q}) < DEPTH_LIM);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_live      = imem_resp_valid && !redirect && (state_q == RUN);

`ifdef FETCH_BYPASS_EN
    assign bypass = rst_n && resp_live && !queued;
`else
    assign bypass = 1'b0;
`endif

    assign dec_valid  = rst_n && !redirect && (queued || bypass);
    assign pop        = rst_n && !redirect && queued && dec_ready;
    assign push       = resp_live && !(bypass && dec_ready);
    assign push_entry = '{instr: imem_resp_data, pc: resp_pc_q};

    always_comb begin
        dec_instr = INSTR_NOP;
        dec_pc    = resp_pc_q;
        if (queued && !redirect) begin
            dec_instr = head.instr;
            dec_pc    = head.pc;
        end else if (bypass) begin
            dec_instr = imem_resp_data;
            dec_pc    = resp_pc_q;
        end
    end

    assign dec_pc_plus4  = dec_pc + XLEN'(4);
    assign outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);

    // On redirect every request still in flight becomes stale; the clamp stops double counting.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d    = state_q;
        drop_cnt_d = drop_cnt_q;
        drop_sum   = '0;
        if (redirect) begin
            drop_sum   = {1'b0, drop_cnt_q} + {1'b0, outstanding_d};
            drop_cnt_d = (drop_sum > {1'b0, outstanding_d}) ? outstanding_d : drop_sum[CW-1:0];
        end else if (imem_resp_valid && state_q == DRAIN) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
        case (state_q)
            RUN:   if (redirect && drop_cnt_d != '0) state_d = DRAIN;
            DRAIN: if (drop_cnt_d == '0)             state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            drop_cnt_q    <= '0;
            outstanding_q <= '0;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
        end else begin
            state_q       <= state_d;
            drop_cnt_q    <= drop_cnt_d;
            outstanding_q <= outstanding_d;
            if (redirect) begin
                fetch_pc_q <= redirect_target;
                resp_pc_q  <= redirect_target;
            end else begin
                if (req_fire)  fetch_pc_q <= fetch_pc_q + XLEN'(4);
                if (resp_live) resp_pc_q  <= resp_pc_q + XLEN'(4);
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .count      (count),
        .head       (head)
    );

endmodule
